// File: rtl/sccomp_if.sv
// Data-memory bus between the single-cycle core and its word-addressed RAM.
// A non-zero byte enable is the write strobe; rdata is a combinational read.
interface sccomp_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;

  modport master (output addr, output wdata, output be, input rdata);
  modport slave  (input addr, input wdata, input be, output rdata);
endinterface

// File: rtl/sccomp.sv
// Single-cycle RV32I computer: core, instruction ROM and data RAM on one clock.
// Define SCCOMP_BYTE_LS_EN to add lb/lh/lbu/lhu/sb/sh; otherwise those decode as NOP.
module sccomp_im #(
  parameter int IM_DEPTH = 128
) (
  input  logic [31:0] addr,
  output logic [31:0] dout
);
  localparam int IW = $clog2(IM_DEPTH);

  logic [31:0] ROM [0:IM_DEPTH-1];
  logic        unused_addr;

  assign dout        = ROM[addr[IW+1:2]];
  assign unused_addr = ^{addr[31:IW+2], addr[1:0]};
endmodule

module sccomp_dm #(
  parameter int DM_DEPTH = 128
) (
  input logic     clk,
  sccomp_if.slave bus
);
  localparam int DW = $clog2(DM_DEPTH);

  logic [31:0]   mem [0:DM_DEPTH-1];
  logic [DW-1:0] idx;
  logic          unused_addr;

  // Word index wraps modulo the depth; byte offset is handled by the core.
  assign idx         = bus.addr[DW+1:2];
  assign bus.rdata   = mem[idx];
  assign unused_addr = ^{bus.addr[31:DW+2], bus.addr[1:0]};

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (bus.be[k]) mem[idx][8*k +: 8] <= bus.wdata[8*k +: 8];
    end
  end
endmodule

module sccomp_rf (
  input  logic        clk,
  input  logic        rstn,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  input  logic [4:0]  raddr3,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  output logic [31:0] rdata3
);
  logic [31:0] rf [1:31];

  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : rf[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : rf[raddr2];
  assign rdata3 = (raddr3 == 5'd0) ? 32'd0 : rf[raddr3];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 1; i < 32; i++) rf[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      rf[waddr] <= wdata;
    end
  end
endmodule

module sccomp_cpu (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] instr,
  output logic [31:0] PC_out,
  input  logic [4:0]  reg_sel,
  output logic [31:0] reg_data,
  sccomp_if.master    dbus
);
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  logic [31:0] pc, pc_plus4, pc_next;
  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, mem_addr, st_wdata, rd_wdata;
  logic [3:0]  st_be;
  logic        rd_we;
  logic [1:0]  br;

  function automatic logic [31:0] alu(input logic [2:0] op, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [31:0]        y;
    sa = a;
    sb = b;
    case (op)
      3'd0:    y = alt ? a - b : a + b;
      3'd1:    y = a << b[4:0];
      3'd2:    y = {31'd0, sa < sb};
      3'd3:    y = {31'd0, a < b};
      3'd4:    y = a ^ b;
      3'd5:    if (alt) y = sa >>> b[4:0]; else y = a >> b[4:0];
      3'd6:    y = a | b;
      default: y = a & b;
    endcase
    return y;
  endfunction

  // Returns {legal, taken}; funct3 010/011 are not branches.
  function automatic logic [1:0] branch(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      3'd0:    return {1'b1, a == b};
      3'd1:    return {1'b1, a != b};
      3'd4:    return {1'b1, sa < sb};
      3'd5:    return {1'b1, sa >= sb};
      3'd6:    return {1'b1, a < b};
      3'd7:    return {1'b1, a >= b};
      default: return 2'b00;
    endcase
  endfunction

`ifdef SCCOMP_BYTE_LS_EN
  // Returns {legal, extended load value}.
  function automatic logic [32:0] load_sub(input logic [2:0] op, input logic [31:0] w,
                                           input logic [1:0] lo);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {lo, 3'b000});
    h = lo[1] ? w[31:16] : w[15:0];
    case (op)
      3'b000:  return {1'b1, {24{b[7]}}, b};
      3'b001:  return {1'b1, {16{h[15]}}, h};
      3'b010:  return {1'b1, w};
      3'b100:  return {1'b1, 24'd0, b};
      3'b101:  return {1'b1, 16'd0, h};
      default: return 33'd0;
    endcase
  endfunction

  // Returns {byte enables, lane-replicated write data}.
  function automatic logic [35:0] store_sub(input logic [2:0] op, input logic [31:0] d,
                                            input logic [1:0] lo);
    case (op)
      3'b000:  return {4'b0001 << lo, {4{d[7:0]}}};
      3'b001:  return {lo[1] ? 4'b1100 : 4'b0011, {2{d[15:0]}}};
      3'b010:  return {4'b1111, d};
      default: return {4'b0000, d};
    endcase
  endfunction
`endif

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign f7     = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'd0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign pc_plus4 = pc + 32'd4;
  assign mem_addr = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign br       = branch(f3, rs1_val, rs2_val);

  sccomp_rf U_RF (
    .clk    (clk),
    .rstn   (rstn),
    .we     (rd_we),
    .waddr  (rd),
    .wdata  (rd_wdata),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .raddr3 (reg_sel),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val),
    .rdata3 (reg_data)
  );

  always_comb begin
    rd_we    = 1'b0;
    rd_wdata = '0;
    pc_next  = pc_plus4;
    st_be    = 4'b0000;
    st_wdata = rs2_val;
    case (opcode)
      OP_R: begin
        if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
          rd_we    = 1'b1;
          rd_wdata = alu(f3, f7[5], rs1_val, rs2_val);
        end
      end
      OP_I: begin
        // Shift-immediates carry funct7 in the immediate field.
        if (!(f3 == 3'd1 && f7 != 7'h00) &&
            !(f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20)) begin
          rd_we    = 1'b1;
          rd_wdata = alu(f3, (f3 == 3'd5) && f7[5], rs1_val, imm_i);
        end
      end
      OP_LUI: begin
        rd_we    = 1'b1;
        rd_wdata = imm_u;
      end
      OP_AUIPC: begin
        rd_we    = 1'b1;
        rd_wdata = pc + imm_u;
      end
      OP_JAL: begin
        rd_we    = 1'b1;
        rd_wdata = pc_plus4;
        pc_next  = pc + imm_j;
      end
      OP_JALR: begin
        if (f3 == 3'd0) begin
          rd_we    = 1'b1;
          rd_wdata = pc_plus4;
          pc_next  = (rs1_val + imm_i) & ~32'd1;
        end
      end
      OP_BR: begin
        if (br[1] && br[0]) pc_next = pc + imm_b;
      end
      OP_LOAD: begin
`ifdef SCCOMP_BYTE_LS_EN
        {rd_we, rd_wdata} = load_sub(f3, dbus.rdata, mem_addr[1:0]);
`else
        if (f3 == 3'b010) begin
          rd_we    = 1'b1;
          rd_wdata = dbus.rdata;
        end
`endif
      end
      OP_STORE: begin
`ifdef SCCOMP_BYTE_LS_EN
        {st_be, st_wdata} = store_sub(f3, rs2_val, mem_addr[1:0]);
`else
        if (f3 == 3'b010) st_be = 4'b1111;
`endif
      end
      default: ;
    endcase
  end

  // RAM must not be written while the core is held in reset.
  assign dbus.addr  = mem_addr;
  assign dbus.wdata = st_wdata;
  assign dbus.be    = rstn ? st_be : 4'b0000;
  assign PC_out     = pc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pc <= '0;
    else       pc <= pc_next;
  end
endmodule

module sccomp #(
  parameter int IM_DEPTH = 128,
  parameter int DM_DEPTH = 128
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  reg_sel,
  output logic [31:0] reg_data
);
  logic [31:0] PC;
  logic [31:0] instr;

  sccomp_if dbus ();

  sccomp_im #(.IM_DEPTH(IM_DEPTH)) U_IM (
    .addr (PC),
    .dout (instr)
  );

  sccomp_cpu U_SCPU (
    .clk      (clk),
    .rstn     (rstn),
    .instr    (instr),
    .PC_out   (PC),
    .reg_sel  (reg_sel),
    .reg_data (reg_data),
    .dbus     (dbus.master)
  );

  sccomp_dm #(.DM_DEPTH(DM_DEPTH)) U_DM (
    .clk (clk),
    .bus (dbus.slave)
  );
endmodule

// File: tb/tb_sccomp.sv
// Scoreboard bench for sccomp: directed programs, PC-trace and register-readback queues
// checked by a monitor on the falling edge, plus a store observer on the RAM bus.
module tb_sccomp;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [4:0]  reg_sel = 5'd0;
  logic [31:0] reg_data;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t        rq[$];
  logic [31:0] pcq[$];
  logic [31:0] prog[$];
  logic [31:0] pc_exp;
  exp_t        r_exp;

  int          st_cnt = 0;
  int          st_bytes = 0;
  logic [31:0] last_addr = '0;
  logic [31:0] last_wdata = '0;
  logic        unused_mon;

  sccomp dut (
    .clk      (clk),
    .rstn     (rstn),
    .reg_sel  (reg_sel),
    .reg_data (reg_data)
  );

  sccomp_if mon ();
  assign mon.addr   = dut.dbus.addr;
  assign mon.wdata  = dut.dbus.wdata;
  assign mon.be     = dut.dbus.be;
  assign mon.rdata  = dut.dbus.rdata;
  assign unused_mon = ^mon.rdata;

  always #5 clk = ~clk;

`ifdef SCCOMP_BYTE_LS_EN
  localparam logic [31:0] E_X19 = 32'h0000_7800, E_X21 = 32'hFFFF_FF80, E_X22 = 32'h0000_0080;
  localparam logic [31:0] E_X23 = 32'h0080_0080, E_X24 = 32'h0000_0080;
  localparam logic [31:0] E_STN = 32'd5, E_STB = 32'd15, E_LA = 32'd14, E_LW = 32'h0080_0080;
`else
  localparam logic [31:0] E_X19 = 32'h0000_0000, E_X21 = 32'h0000_0055, E_X22 = 32'h0000_0000;
  localparam logic [31:0] E_X23 = 32'h0000_0080, E_X24 = 32'h0000_0000;
  localparam logic [31:0] E_STN = 32'd3, E_STB = 32'd12, E_LA = 32'd12, E_LW = 32'h0000_0080;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one PC-trace entry and one register readback per falling edge.
  always @(negedge clk) begin
    if (rstn && pcq.size() > 0) begin
      pc_exp = pcq.pop_front();
      check("pc_trace", dut.PC, pc_exp);
    end
    if (rq.size() > 0) begin
      r_exp = rq.pop_front();
      check(r_exp.name, reg_data, r_exp.val);
    end
  end

  always @(negedge clk) begin
    if (!rstn) begin
      st_cnt   = 0;
      st_bytes = 0;
    end else if (mon.be != 4'b0000) begin
      st_cnt++;
      st_bytes  += $countones(mon.be);
      last_addr  = mon.addr;
      last_wdata = mon.wdata;
    end
  end

  task automatic load_prog();
    for (int i = 0; i < 128; i++) dut.U_IM.ROM[i] = 32'h0000_0013;
    for (int i = 0; i < prog.size(); i++) dut.U_IM.ROM[i] = prog[i];
  endtask

  task automatic start();
    rstn = 1'b0;
    load_prog();
    #20;
    @(posedge clk);
    #2 rstn = 1'b1;
  endtask

  task automatic wait_trace();
    int n = 0;
    while (pcq.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("trace_drained", 32'(pcq.size()), 32'd0);
    pcq.delete();
  endtask

  task automatic chk_reg(input string name, input logic [4:0] sel, input logic [31:0] val);
    @(posedge clk);
    #1 reg_sel = sel;
    rq.push_back('{name: name, val: val});
    @(negedge clk);
    #1;
  endtask

  task automatic linear_trace(input int last_idx);
    for (int i = 0; i <= last_idx; i++) pcq.push_back(32'(i * 4));
    repeat (3) pcq.push_back(32'(last_idx * 4));
  endtask

  initial begin
    // Reset state
    reg_sel = 5'd7;
    rq.push_back('{name: "rst_x7", val: 32'd0});
    #12;
    check("rst_pc", dut.PC, 32'd0);

    // Program A: ALU, immediates, x0 protection, undefined opcode
    prog = '{32'h00500093, 32'hFFD00113, 32'h002081B3, 32'h40208233, 32'h401152B3,
             32'h00112333, 32'h001133B3, 32'h00900593, 32'h00700013, 32'h000005B3,
             32'h0020C633, 32'h001096B3, 32'h01C15713, 32'h0F017793, 32'hFF00E813,
             32'hFFE12893, 32'hFFF0B913, 32'hFFFFFFFF, 32'h0000006F};
    linear_trace(18);
    start();
    wait_trace();
    chk_reg("a_x1", 5'd1, 32'd5);
    chk_reg("a_x2", 5'd2, 32'hFFFF_FFFD);
    chk_reg("a_x3_add", 5'd3, 32'd2);
    chk_reg("a_x4_sub", 5'd4, 32'd8);
    chk_reg("a_x5_sra", 5'd5, 32'hFFFF_FFFF);
    chk_reg("a_x6_slt", 5'd6, 32'd1);
    chk_reg("a_x7_sltu", 5'd7, 32'd0);
    chk_reg("a_x0", 5'd0, 32'd0);
    chk_reg("a_x11", 5'd11, 32'd0);
    chk_reg("a_x12_xor", 5'd12, 32'hFFFF_FFF8);
    chk_reg("a_x13_sll", 5'd13, 32'h0000_00A0);
    chk_reg("a_x14_srli", 5'd14, 32'h0000_000F);
    chk_reg("a_x15_andi", 5'd15, 32'h0000_00F0);
    chk_reg("a_x16_ori", 5'd16, 32'hFFFF_FFF5);
    chk_reg("a_x17_slti", 5'd17, 32'd1);
    chk_reg("a_x18_sltiu", 5'd18, 32'd1);
    chk_reg("a_x31_undef", 5'd31, 32'd0);

    // Program B: upper, memory, byte/half access, address wrap; async reset mid-run first
    prog = '{32'h12345437, 32'h67840413, 32'h00802423, 32'h00802483, 32'h00001517,
             32'h00002023, 32'h008000A3, 32'h00002983, 32'h08000A13, 32'h01402623,
             32'h05500A93, 32'h00C00A83, 32'h00C04B03, 32'h01401723, 32'h00C02B83,
             32'h00E01C03, 32'h20802C83, 32'h00B02D03, 32'h0000006F};
    start();
    repeat (3) @(posedge clk);
    #3 reg_sel = 5'd8;
    #1 check("pre_x8", reg_data, 32'h1234_5678);
    rstn = 1'b0;
    #1;
    check("async_pc", dut.PC, 32'd0);
    check("async_x8", reg_data, 32'd0);
    linear_trace(18);
    start();
    wait_trace();
    chk_reg("b_x8_lui", 5'd8, 32'h1234_5678);
    chk_reg("b_x9_lw", 5'd9, 32'h1234_5678);
    chk_reg("b_x10_auipc", 5'd10, 32'h0000_1010);
    chk_reg("b_x19_sb", 5'd19, E_X19);
    chk_reg("b_x20", 5'd20, 32'h0000_0080);
    chk_reg("b_x21_lb", 5'd21, E_X21);
    chk_reg("b_x22_lbu", 5'd22, E_X22);
    chk_reg("b_x23_sh", 5'd23, E_X23);
    chk_reg("b_x24_lh", 5'd24, E_X24);
    chk_reg("b_x25_wrap", 5'd25, 32'h1234_5678);
    chk_reg("b_x26_misal", 5'd26, 32'h1234_5678);
    check("b_store_count", 32'(st_cnt), E_STN);
    check("b_store_bytes", 32'(st_bytes), E_STB);
    check("b_last_st_addr", last_addr, E_LA);
    check("b_last_st_data", last_wdata, E_LW);

    // Program C: branches taken/not taken, jal, jalr with bit-0 clear
    prog = '{32'h00000463, 32'h00100293, 32'h00001463, 32'h00200313, 32'hFFF00393,
             32'h0063C463, 32'h00100293, 32'h0063E463, 32'h00C000EF, 32'h0140006F,
             32'h00100293, 32'h00300413, 32'h00008067, 32'h00100293, 32'h00735463,
             32'h00100293, 32'h04D00593, 32'h00058567, 32'h00100293, 32'h0000006F};
    pcq = '{32'h00, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h1C, 32'h20, 32'h2C, 32'h30,
            32'h24, 32'h38, 32'h40, 32'h44, 32'h4C, 32'h4C, 32'h4C};
    start();
    wait_trace();
    chk_reg("c_x1_jal", 5'd1, 32'h0000_0024);
    chk_reg("c_x5_skips", 5'd5, 32'd0);
    chk_reg("c_x6", 5'd6, 32'd2);
    chk_reg("c_x7", 5'd7, 32'hFFFF_FFFF);
    chk_reg("c_x8", 5'd8, 32'd3);
    chk_reg("c_x10_jalr", 5'd10, 32'h0000_0048);
    chk_reg("c_x11", 5'd11, 32'h0000_004D);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
